// File: rtl/led_pkg.sv
// ============================================================================
//  Module      : led_pkg
//  Description : Shared types and helpers for the LED matrix SPI receive path.
//                Holds the receiver FSM state encoding, the default frame sync
//                byte and the pixel-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package led_pkg;

  // Receiver FSM states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SYNC   = 3'd1,
    PIX_LO = 3'd2,
    PIX_HI = 3'd3,
    CSUM   = 3'd4,
    DONE   = 3'd5,
    FLUSH  = 3'd6
  } state_t;

  // Default first byte of every frame.
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // Pixel width in bits for a given colour depth (three colour channels).
  function automatic int pix_width(input int cdepth);
    return 3 * cdepth;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_byte_rx.sv
// ============================================================================
//  Module      : spi_byte_rx
//  Description : SPI slave byte deserialiser. Synchronises sck/sdi/cs_n into
//                the clk domain, detects rising sck, shifts sdi in MSB-first
//                while chip select is active and flags each completed byte.
//  Ports       : clk        - system clock
//                reset      - synchronous active-low reset
//                sck        - SPI clock (asynchronous)
//                sdi        - SPI data (asynchronous)
//                cs_n       - SPI chip select, active-low (asynchronous)
//                rx_byte    - last completed byte
//                byte_valid - one-cycle strobe, rx_byte just completed
//                cs_active  - synchronised chip select is asserted
//                cs_fall    - one-cycle strobe, chip select became active
//                cs_rise    - one-cycle strobe, chip select became inactive
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_byte_rx (
  input  logic       clk,
  input  logic       reset,
  input  logic       sck,
  input  logic       sdi,
  input  logic       cs_n,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       cs_active,
  output logic       cs_fall,
  output logic       cs_rise
);

  logic       sck_s1, sck_s2, sck_d;
  logic       sdi_s1, sdi_s2;
  logic       cs_s1, cs_s2, cs_d;
  logic [2:0] bit_cnt;
  // Only seven bits are kept; the eighth goes straight into rx_byte.
  logic [6:0] shift;
  logic       sck_rise;

  assign sck_rise  = sck_s2 & ~sck_d;
  assign cs_active = ~cs_s2;
  assign cs_fall   = cs_d & ~cs_s2;
  assign cs_rise   = ~cs_d & cs_s2;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sck_s1     <= 1'b0;
      sck_s2     <= 1'b0;
      sck_d      <= 1'b0;
      sdi_s1     <= 1'b0;
      sdi_s2     <= 1'b0;
      cs_s1      <= 1'b0;
      cs_s2      <= 1'b0;
      cs_d       <= 1'b0;
      bit_cnt    <= 3'd0;
      shift      <= 7'd0;
      rx_byte    <= 8'd0;
      byte_valid <= 1'b0;
    end else begin
      sck_s1     <= sck;
      sck_s2     <= sck_s1;
      sck_d      <= sck_s2;
      sdi_s1     <= sdi;
      sdi_s2     <= sdi_s1;
      cs_s1      <= cs_n;
      cs_s2      <= cs_s1;
      cs_d       <= cs_s2;
      byte_valid <= 1'b0;
      if (!cs_active) begin
        // Deselected: discard any partial byte so the next frame starts aligned.
        bit_cnt <= 3'd0;
        shift   <= 7'd0;
      end else if (sck_rise) begin
        shift   <= {shift[5:0], sdi_s2};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          rx_byte    <= {shift, sdi_s2};
          byte_valid <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/spi_frame_rx.sv
// ============================================================================
//  Module      : spi_frame_rx
//  Description : SPI frame receiver for the LED matrix path. Accepts frames of
//                [sync byte][2 bytes per pixel, low byte first][checksum] and
//                streams pixel writes to the downstream frame buffer. Each
//                frame ends with exactly one of fdone / ferr / fdrop.
//                Writes are not held back until validation; the buffer only
//                treats its contents as a committed frame on fdone.
//  Config      : SPI_FRAME_CSUM_EN - when defined, a trailing XOR checksum
//                byte over all pixel bytes is required and checked. When not
//                defined, fdone follows the last pixel and any extra byte is
//                absorbed while flushing.
//  Ports       : clk   - system clock
//                reset - synchronous active-low reset
//                sck, sdi, cs_n - SPI slave pins (asynchronous)
//                busy  - downstream still consuming previous frame
//                we, waddr, wpix - pixel write strobe, address, data
//                fdone - frame complete and valid (pulse)
//                ferr  - frame aborted or corrupt (pulse)
//                fdrop - frame ignored because busy was high (pulse)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_frame_rx
  import led_pkg::*;
#(
  parameter int         CDEPTH      = 4,
  parameter int         FRAME_ORDER = 10,
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sck,
  input  logic                   sdi,
  input  logic                   cs_n,
  input  logic                   busy,
  output logic                   we,
  output logic [FRAME_ORDER-1:0] waddr,
  output logic [3*CDEPTH-1:0]    wpix,
  output logic                   fdone,
  output logic                   ferr,
  output logic                   fdrop
);

  // Pixel width; must not exceed the 16 bits carried by two bytes.
  localparam int PW = pix_width(CDEPTH);

  logic [7:0]    rx_byte;
  logic          byte_valid;
  logic          cs_active;
  logic          cs_fall;
  logic          cs_rise;

  state_t        state;
  state_t        next_state;
  logic [7:0]    lo_byte;
  logic [PW-1:0] pix_word;
  logic          frame_start;
  logic          lo_take;
`ifdef SPI_FRAME_CSUM_EN
  logic [7:0]    csum;
`endif

  spi_byte_rx u_byte_rx (
    .clk        (clk),
    .reset      (reset),
    .sck        (sck),
    .sdi        (sdi),
    .cs_n       (cs_n),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .cs_active  (cs_active),
    .cs_fall    (cs_fall),
    .cs_rise    (cs_rise)
  );

  // Pixel = {hi, lo} truncated to the pixel width.
  generate
    if (PW > 8) begin : g_wide
      assign pix_word = {rx_byte[PW-9:0], lo_byte};
    end else begin : g_narrow
      assign pix_word = lo_byte[PW-1:0];
    end
  endgenerate

  assign wpix        = we ? pix_word : '0;
  assign frame_start = (state == SYNC) && (next_state == PIX_LO);
  assign lo_take     = (state == PIX_LO) && (next_state == PIX_HI);

  always_comb begin
    next_state = state;
    we         = 1'b0;
    fdone      = 1'b0;
    ferr       = 1'b0;
    fdrop      = 1'b0;
    case (state)
      IDLE: begin
        // Chip select already low without a seen falling edge (e.g. coming
        // out of reset mid-frame): wait out the current frame in FLUSH.
        if (cs_fall)        next_state = SYNC;
        else if (cs_active) next_state = FLUSH;
      end
      SYNC: begin
        if (cs_rise) begin
          ferr       = 1'b1;
          next_state = IDLE;
        end else if (byte_valid) begin
          if (rx_byte != SYNC_BYTE) begin
            ferr       = 1'b1;
            next_state = FLUSH;
          end else if (busy) begin
            fdrop      = 1'b1;
            next_state = FLUSH;
          end else begin
            next_state = PIX_LO;
          end
        end
      end
      PIX_LO: begin
        if (cs_rise) begin
          ferr       = 1'b1;
          next_state = IDLE;
        end else if (byte_valid) begin
          next_state = PIX_HI;
        end
      end
      PIX_HI: begin
        if (cs_rise) begin
          ferr       = 1'b1;
          next_state = IDLE;
        end else if (byte_valid) begin
          we = 1'b1;
          if (&waddr) begin
`ifdef SPI_FRAME_CSUM_EN
            next_state = CSUM;
`else
            next_state = DONE;
`endif
          end else begin
            next_state = PIX_LO;
          end
        end
      end
`ifdef SPI_FRAME_CSUM_EN
      CSUM: begin
        if (cs_rise) begin
          ferr       = 1'b1;
          next_state = IDLE;
        end else if (byte_valid) begin
          if (rx_byte == csum) begin
            next_state = DONE;
          end else begin
            ferr       = 1'b1;
            next_state = FLUSH;
          end
        end
      end
`endif
      DONE: begin
        fdone      = 1'b1;
        next_state = FLUSH;
      end
      FLUSH: begin
        // Level test rather than edge so a deselect coinciding with DONE
        // is not missed.
        if (!cs_active) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      waddr   <= '0;
      lo_byte <= 8'd0;
`ifdef SPI_FRAME_CSUM_EN
      csum    <= 8'd0;
`endif
    end else begin
      state <= next_state;
      if (frame_start) begin
        waddr <= '0;
`ifdef SPI_FRAME_CSUM_EN
        csum  <= 8'd0;
`endif
      end
      if (lo_take) begin
        lo_byte <= rx_byte;
`ifdef SPI_FRAME_CSUM_EN
        csum    <= csum ^ rx_byte;
`endif
      end
      if (we) begin
        waddr <= waddr + {{(FRAME_ORDER-1){1'b0}}, 1'b1};
`ifdef SPI_FRAME_CSUM_EN
        csum  <= csum ^ rx_byte;
`endif
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_frame_rx.sv
// ============================================================================
//  Module      : tb_spi_frame_rx
//  Description : Directed self-checking bench for spi_frame_rx with
//                FRAME_ORDER=2 (4 pixels) and CDEPTH=4. Expected results
//                follow SPI_FRAME_CSUM_EN as seen by this file.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_frame_rx;

  localparam int CDEPTH      = 4;
  localparam int FRAME_ORDER = 2;
  localparam int PW          = 3 * CDEPTH;
`ifdef SPI_FRAME_CSUM_EN
  localparam int VALID_LEN   = 10;
`else
  localparam int VALID_LEN   = 9;
`endif

  logic                   clk   = 1'b0;
  logic                   reset = 1'b0;
  logic                   sck   = 1'b0;
  logic                   sdi   = 1'b0;
  logic                   cs_n  = 1'b1;
  logic                   busy  = 1'b0;
  logic                   we;
  logic [FRAME_ORDER-1:0] waddr;
  logic [PW-1:0]          wpix;
  logic                   fdone;
  logic                   ferr;
  logic                   fdrop;

  spi_frame_rx #(
    .CDEPTH      (CDEPTH),
    .FRAME_ORDER (FRAME_ORDER),
    .SYNC_BYTE   (8'hA5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .sck   (sck),
    .sdi   (sdi),
    .cs_n  (cs_n),
    .busy  (busy),
    .we    (we),
    .waddr (waddr),
    .wpix  (wpix),
    .fdone (fdone),
    .ferr  (ferr),
    .fdrop (fdrop)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Frame image: sync, four pixels (lo,hi), checksum.
  logic [7:0] fb [0:9] = '{8'hA5, 8'h23, 8'h01, 8'h56, 8'h04,
                           8'h89, 8'h07, 8'hBC, 8'h0A, 8'h48};
  logic [31:0] exp_pix [0:3] = '{32'h123, 32'h456, 32'h789, 32'hABC};

  // Output monitor, sampled on the falling edge.
  int          cyc         = 0;
  int          last_we_cyc = 0;
  int          done_cyc    = 0;
  int          n_done      = 0;
  int          n_err       = 0;
  int          n_drop      = 0;
  logic [31:0] wr_addr_q [$];
  logic [31:0] wr_pix_q  [$];

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      if (we) begin
        wr_addr_q.push_back(32'(waddr));
        wr_pix_q.push_back(32'(wpix));
        last_we_cyc = cyc;
      end
      if (fdone) begin
        n_done++;
        done_cyc = cyc;
      end
      if (ferr)  n_err++;
      if (fdrop) n_drop++;
    end
  end

  task automatic clear_mon();
    @(posedge clk);
    wr_addr_q.delete();
    wr_pix_q.delete();
    n_done = 0;
    n_err  = 0;
    n_drop = 0;
  endtask

  task automatic spi_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk);
      sdi = b[i];
      repeat (4) @(negedge clk);
      sck = 1'b1;
      repeat (4) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  task automatic send_frame(input int n);
    cs_n = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < n; i++) spi_byte(fb[i]);
    repeat (6) @(negedge clk);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // Expect the first n pixels of the reference frame, starting at address 0.
  task automatic check_writes(input string tag, input int n);
    logic [31:0] a, p;
    check_val({tag, "_nwe"}, 32'(wr_addr_q.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      a = (i < wr_addr_q.size()) ? wr_addr_q[i] : 32'hFFFF_FFFF;
      p = (i < wr_pix_q.size())  ? wr_pix_q[i]  : 32'hFFFF_FFFF;
      check_val({tag, "_addr"}, a, 32'(i));
      check_val({tag, "_pix"},  p, exp_pix[i]);
    end
  endtask

  task automatic check_pulses(input string tag, input int d, input int e, input int p);
    check_val({tag, "_fdone"}, 32'(n_done), 32'(d));
    check_val({tag, "_ferr"},  32'(n_err),  32'(e));
    check_val({tag, "_fdrop"}, 32'(n_drop), 32'(p));
  endtask

  initial begin
    // Reset with random pin activity.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      sck  = 1'($urandom);
      sdi  = 1'($urandom);
      cs_n = 1'($urandom);
      busy = 1'($urandom);
    end
    @(negedge clk);
    check_val("rst_we",    32'(we),    32'h0);
    check_val("rst_waddr", 32'(waddr), 32'h0);
    check_val("rst_wpix",  32'(wpix),  32'h0);
    check_val("rst_fdone", 32'(fdone), 32'h0);
    check_val("rst_ferr",  32'(ferr),  32'h0);
    check_val("rst_fdrop", 32'(fdrop), 32'h0);
    sck  = 1'b0;
    sdi  = 1'b0;
    cs_n = 1'b1;
    busy = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    clear_mon();

    // Valid frame.
    send_frame(VALID_LEN);
    check_writes("valid", 4);
    check_pulses("valid", 1, 0, 0);
`ifdef SPI_FRAME_CSUM_EN
    check_val("valid_done_after_csum", 32'((done_cyc - last_we_cyc) > 16), 32'h1);
`else
    check_val("valid_done_next", 32'(done_cyc - last_we_cyc), 32'h1);
`endif
    clear_mon();

    // Corrupt checksum (absorbed as a stray byte when checksum is off).
    fb[9] = 8'h49;
    send_frame(10);
    fb[9] = 8'h48;
    check_writes("badcs", 4);
`ifdef SPI_FRAME_CSUM_EN
    check_pulses("badcs", 0, 1, 0);
`else
    check_pulses("badcs", 1, 0, 0);
`endif
    clear_mon();

    // Bad sync byte followed by eight bytes, then a good frame.
    fb[0] = 8'h5A;
    send_frame(9);
    fb[0] = 8'hA5;
    check_writes("badsync", 0);
    check_pulses("badsync", 0, 1, 0);
    clear_mon();
    send_frame(VALID_LEN);
    check_writes("aftersync", 4);
    check_pulses("aftersync", 1, 0, 0);
    clear_mon();

    // Abort after one pixel and a half, then a good frame from address 0.
    send_frame(4);
    check_writes("abort", 1);
    check_pulses("abort", 0, 1, 0);
    clear_mon();
    send_frame(VALID_LEN);
    check_writes("afterabort", 4);
    check_pulses("afterabort", 1, 0, 0);
    clear_mon();

    // Downstream busy at the sync byte.
    busy = 1'b1;
    send_frame(VALID_LEN);
    busy = 1'b0;
    check_writes("busy", 0);
    check_pulses("busy", 0, 0, 1);
    clear_mon();

    // Reset mid-frame while cs_n stays low: rest of frame ignored, no pulse.
    cs_n = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 3; i++) spi_byte(fb[i]);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    clear_mon();
    for (int i = 3; i < VALID_LEN; i++) spi_byte(fb[i]);
    repeat (6) @(negedge clk);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
    check_writes("rstmid", 0);
    check_pulses("rstmid", 0, 0, 0);
    clear_mon();
    send_frame(VALID_LEN);
    check_writes("afterrst", 4);
    check_pulses("afterrst", 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
